pipeline_stage_buffer: RTL

PIPELINE_STAGE_BUFFER -- requirements
Module: pipeline_stage_buffer

---
 rtl/pipeline_stage_buffer_pkg.sv | 13 +
 rtl/pipeline_stage_buffer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipeline_stage_buffer_pkg.sv
// Shared pipeline definitions: skid-buffer FSM states and the bubble instruction.
package pipeline_stage_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // RISC-V addi x0,x0,0
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pipeline_stage_buffer.sv
// Two-entry skid buffer between fetch and decode. Handshake readiness comes from
// registered state only, and the outputs show a (0, NOP) bubble whenever out_valid is low.
module pipeline_stage_buffer
  import pipeline_stage_buffer_pkg::*;
#(
  parameter int               Width = 32,
  parameter int               Depth = 32,
  parameter logic [Depth-1:0] NOP   = Depth'(NOP_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] Address_in,
  input  logic [Depth-1:0] Instruction_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] Address_out,
  output logic [Depth-1:0] Instruction_out,
  output logic [1:0]       occupancy
);

  buf_state_t state, state_n;

  logic [Width-1:0] main_addr,  skid_addr;
  logic [Depth-1:0] main_instr, skid_instr;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid, load_bubble;

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    load_bubble    = 1'b0;
    if (flush) begin
      // Flush outranks any handshake; an input accepted this cycle is dropped.
      state_n     = EMPTY;
      load_bubble = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_n      = BUSY;
            load_main_in = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_n     = EMPTY;
            load_bubble = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_n        = BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_n     = EMPTY;
          load_bubble = 1'b1;
        end
      endcase
    end
  end

  // NOTE: both data registers are reset on purpose -- the bubble on the outputs
  // after reset is architecturally visible, unlike a plain storage array.
  always_ff @(posedge clk) begin
    if (reset || load_bubble) begin
      main_addr  <= '0;
      main_instr <= NOP;
      skid_addr  <= '0;
      skid_instr <= NOP;
    end else begin
      if (load_main_in) begin
        main_addr  <= Address_in;
        main_instr <= Instruction_in;
      end else if (load_main_skid) begin
        main_addr  <= skid_addr;
        main_instr <= skid_instr;
      end
      if (load_skid) begin
        skid_addr  <= Address_in;
        skid_instr <= Instruction_in;
      end
    end
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    unique case (state)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign Address_out     = main_addr;
  assign Instruction_out = main_instr;

endmodule
